// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting sequencer for the clock2 chain.
// Two raw active-low keys are synchronized and debounced into press events.
// Those events walk an hours -> minutes -> seconds edit sequence. Each field
// is a BCD value. The final mode press issues a one-cycle active-low load strobe.
//
// state  | meaning
// IDLE   | not editing, load values held
// HRS    | editing hours   (00..23)
// MINS   | editing minutes (00..59)
// SECS   | editing seconds (00..59)
// COMMIT | one-cycle nLoadNow_o strobe, then back to IDLE
module clock_set_ctrl #(
    parameter int DEBOUNCE_TC_P = 500000,
    parameter int BLINK_TC_P    = 12499999
) (
    input  logic       clk_i,
    input  logic       nReset_i,
    input  logic       nModeKey_i,
    input  logic       nIncKey_i,
    output logic [7:0] load_hrs_o,
    output logic [7:0] load_mins_o,
    output logic [7:0] load_secs_o,
    output logic       nLoadNow_o,
    output logic [1:0] editField_o,
    output logic       editing_o,
    output logic       blink_o
);

    localparam int DB_W = (DEBOUNCE_TC_P > 0) ? $clog2(DEBOUNCE_TC_P + 1) : 1;
    localparam int BL_W = (BLINK_TC_P > 0) ? $clog2(BLINK_TC_P + 1) : 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_TC_P);
    localparam logic [BL_W-1:0] BL_TC = BL_W'(BLINK_TC_P);

    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HRS,
        ST_MINS,
        ST_SECS,
        ST_COMMIT
    } state_t;

    logic [1:0]      rst_sync_q;
    logic            rst_b;

    logic [1:0]      key_raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      level_q;
    logic [1:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [2];

    state_t          state_q, state_d;
    logic [7:0]      hrs_q, hrs_d;
    logic [7:0]      mins_q, mins_d;
    logic [7:0]      secs_q, secs_d;
    logic            nload_q, nload_d;
    logic [1:0]      field_q, field_d;
    logic            editing_q, editing_d;
    logic            blink_q, blink_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;

    logic            mode_ev;
    logic            inc_ev;

    // The limit check comes first, so 23 and 59 wrap the whole field to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Reset synchronizer: reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_b   = rst_sync_q[1] & nReset_i;
    assign key_raw = {nIncKey_i, nModeKey_i};

    // Synchronize both keys, then debounce them with a terminal-count down-counter.
    // A press pulse is registered on each debounced 1->0 flip.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            level_q <= 2'b11;
            press_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= DB_TC;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            press_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] == level_q[k]) begin
                    db_cnt_q[k] <= DB_TC;
                end else if (db_cnt_q[k] == '0) begin
                    level_q[k]  <= sync2_q[k];
                    db_cnt_q[k] <= DB_TC;
                    press_q[k]  <= ~sync2_q[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] - 1'b1;
                end
            end
        end
    end

    assign mode_ev = press_q[KEY_MODE];
    assign inc_ev  = press_q[KEY_INC];

    // Next-state, field edits and next-output decode.
    // Mode has priority over a coincident inc.
    always_comb begin
        state_d     = state_q;
        hrs_d       = hrs_q;
        mins_d      = mins_q;
        secs_d      = secs_q;
        field_d     = 2'd0;
        editing_d   = 1'b0;
        nload_d     = 1'b1;
        blink_d     = 1'b0;
        blink_cnt_d = BL_TC;

        case (state_q)
            ST_IDLE: begin
                if (mode_ev) state_d = ST_HRS;
            end
            ST_HRS: begin
                if (mode_ev)     state_d = ST_MINS;
                else if (inc_ev) hrs_d   = bcd_inc(hrs_q, 8'h23);
            end
            ST_MINS: begin
                if (mode_ev)     state_d = ST_SECS;
                else if (inc_ev) mins_d  = bcd_inc(mins_q, 8'h59);
            end
            ST_SECS: begin
                if (mode_ev)     state_d = ST_COMMIT;
                else if (inc_ev) secs_d  = bcd_inc(secs_q, 8'h59);
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_HRS:    begin field_d = 2'd1; editing_d = 1'b1; end
            ST_MINS:   begin field_d = 2'd2; editing_d = 1'b1; end
            ST_SECS:   begin field_d = 2'd3; editing_d = 1'b1; end
            ST_COMMIT: nload_d = 1'b0;
            default:   ;
        endcase

        // Blink restarts from phase 0 on every entry into an edit field.
        if (editing_d && (state_d == state_q)) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d = BL_TC;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    // State, field values and registered outputs.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            hrs_q       <= 8'h00;
            mins_q      <= 8'h00;
            secs_q      <= 8'h00;
            nload_q     <= 1'b1;
            field_q     <= 2'd0;
            editing_q   <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= BL_TC;
        end else begin
            state_q     <= state_d;
            hrs_q       <= hrs_d;
            mins_q      <= mins_d;
            secs_q      <= secs_d;
            nload_q     <= nload_d;
            field_q     <= field_d;
            editing_q   <= editing_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign load_hrs_o  = hrs_q;
    assign load_mins_o = mins_q;
    assign load_secs_o = secs_q;
    assign nLoadNow_o  = nload_q;
    assign editField_o = field_q;
    assign editing_o   = editing_q;
    assign blink_o     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;

    logic       clk_i = 1'b0;
    logic       nReset_i;
    logic       nModeKey_i;
    logic       nIncKey_i;
    logic [7:0] load_hrs_o;
    logic [7:0] load_mins_o;
    logic [7:0] load_secs_o;
    logic       nLoadNow_o;
    logic [1:0] editField_o;
    logic       editing_o;
    logic       blink_o;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;
    logic [7:0] cap_hrs, cap_mins, cap_secs;

    clock_set_ctrl #(
        .DEBOUNCE_TC_P(3),
        .BLINK_TC_P   (7)
    ) dut (
        .clk_i      (clk_i),
        .nReset_i   (nReset_i),
        .nModeKey_i (nModeKey_i),
        .nIncKey_i  (nIncKey_i),
        .load_hrs_o (load_hrs_o),
        .load_mins_o(load_mins_o),
        .load_secs_o(load_secs_o),
        .nLoadNow_o (nLoadNow_o),
        .editField_o(editField_o),
        .editing_o  (editing_o),
        .blink_o    (blink_o)
    );

    always #5 clk_i = ~clk_i;

    // Count strobe cycles and capture the load values seen during the strobe.
    always @(negedge clk_i) begin
        if (!nLoadNow_o) begin
            strobe_cnt = strobe_cnt + 1;
            cap_hrs    = load_hrs_o;
            cap_mins   = load_mins_o;
            cap_secs   = load_secs_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_mode();
        @(negedge clk_i); nModeKey_i = 1'b0;
        repeat (8) @(negedge clk_i);
        nModeKey_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i); nIncKey_i = 1'b0;
            repeat (8) @(negedge clk_i);
            nIncKey_i = 1'b1;
            repeat (8) @(negedge clk_i);
        end
    endtask

    task automatic press_both();
        @(negedge clk_i); nModeKey_i = 1'b0; nIncKey_i = 1'b0;
        repeat (8) @(negedge clk_i);
        nModeKey_i = 1'b1; nIncKey_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hrs"},   load_hrs_o,  8'h00);
        chk({tag, "_mins"},  load_mins_o, 8'h00);
        chk({tag, "_secs"},  load_secs_o, 8'h00);
        chk({tag, "_nload"}, nLoadNow_o,  1'b1);
        chk({tag, "_field"}, editField_o, 2'd0);
        chk({tag, "_edit"},  editing_o,   1'b0);
        chk({tag, "_blink"}, blink_o,     1'b0);
    endtask

    initial begin
        int s0;
        bit found;
        nReset_i   = 1'b0;
        nModeKey_i = 1'b1;
        nIncKey_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("por");
        nReset_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // 1: asynchronous reset mid-edit
        press_mode();
        chk("t1_field_hrs", editField_o, 2'd1);
        chk("t1_editing", editing_o, 1'b1);
        press_inc(3);
        chk("t1_hrs03", load_hrs_o, 8'h03);
        @(negedge clk_i); #2 nReset_i = 1'b0;
        #1 check_reset_outputs("t1_async");
        @(negedge clk_i); nReset_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("t1_idle_field", editField_o, 2'd0);
        chk("t1_idle_hrs", load_hrs_o, 8'h00);

        // 2: glitch rejection and single event on a long hold
        @(negedge clk_i); nModeKey_i = 1'b0;
        repeat (3) @(negedge clk_i);
        nModeKey_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("t2_glitch", editField_o, 2'd0);
        nModeKey_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk("t2_hold8", editField_o, 2'd1);
        repeat (20) @(negedge clk_i);
        chk("t2_hold_long", editField_o, 2'd1);
        nModeKey_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("t2_release", editField_o, 2'd1);

        // 3: hours wrap and tens carry
        press_inc(9);
        chk("t3_hrs09", load_hrs_o, 8'h09);
        press_inc(1);
        chk("t3_hrs10", load_hrs_o, 8'h10);
        press_inc(13);
        chk("t3_hrs23", load_hrs_o, 8'h23);
        press_inc(1);
        chk("t3_hrs_wrap", load_hrs_o, 8'h00);

        // 4: enter 12:34:56 and commit
        press_inc(12);
        chk("t4_hrs12", load_hrs_o, 8'h12);
        press_mode();
        chk("t4_field_mins", editField_o, 2'd2);
        press_inc(34);
        chk("t4_mins34", load_mins_o, 8'h34);
        press_mode();
        chk("t4_field_secs", editField_o, 2'd3);
        press_inc(56);
        chk("t4_secs56", load_secs_o, 8'h56);
        s0 = strobe_cnt;
        press_mode();
        chk("t4_strobe_cycles", strobe_cnt - s0, 1);
        chk("t4_cap_hrs", cap_hrs, 8'h12);
        chk("t4_cap_mins", cap_mins, 8'h34);
        chk("t4_cap_secs", cap_secs, 8'h56);
        chk("t4_editing_off", editing_o, 1'b0);
        chk("t4_field_idle", editField_o, 2'd0);
        chk("t4_keep_hrs", load_hrs_o, 8'h12);
        chk("t4_keep_secs", load_secs_o, 8'h56);

        // 5: mode wins over a coincident inc; inc ignored in IDLE
        press_mode();
        press_mode();
        chk("t5_field_mins", editField_o, 2'd2);
        chk("t5_mins_start", load_mins_o, 8'h34);
        press_inc(25);
        chk("t5_mins59", load_mins_o, 8'h59);
        press_both();
        chk("t5_field_secs", editField_o, 2'd3);
        chk("t5_mins_kept", load_mins_o, 8'h59);
        s0 = strobe_cnt;
        press_mode();
        chk("t5_strobe", strobe_cnt - s0, 1);
        press_inc(1);
        chk("t5_idle_field", editField_o, 2'd0);
        chk("t5_idle_hrs", load_hrs_o, 8'h12);
        chk("t5_idle_mins", load_mins_o, 8'h59);
        chk("t5_idle_secs", load_secs_o, 8'h56);

        // 6: blink period in MINS, then reset without strobe
        press_mode();
        chk("t6_field_hrs", editField_o, 2'd1);
        @(negedge clk_i); nModeKey_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (editField_o == 2'd2) found = 1'b1;
        end
        chk("t6_mins_entered", found, 1'b1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t6_blink_%0d", k), blink_o, ((k / 8) % 2));
            @(negedge clk_i);
        end
        nModeKey_i = 1'b1;
        s0 = strobe_cnt;
        #2 nReset_i = 1'b0;
        #1 check_reset_outputs("t6_reset");
        @(negedge clk_i); nReset_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("t6_no_strobe", strobe_cnt - s0, 0);
        chk("t6_idle", editField_o, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting sequencer for the clock2 counter chain. It turns two raw, active-low push buttons into a guided hours → minutes → seconds edit sequence, and accumulates the new time as BCD. On commit it issues a single-cycle active-low load strobe with parallel load values to clock2. It also drives edit-field and blink indicators for the display blanker.

Parameters:
DEBOUNCE_TC_P, 500000, a debounced level changes only after the synchronized input has differed from it for DEBOUNCE_TC_P+1 consecutive cycles (10 ms at 50 MHz).
BLINK_TC_P, 12499999, blink_o toggles every BLINK_TC_P+1 cycles while editing (2 Hz blink at 50 MHz).

Ports:
clk_i  input  1  system clock (CLOCK_50)
nReset_i  input  1  asynchronous active-low reset
nModeKey_i  input  1  raw mode button, active-low, asynchronous to clk_i
nIncKey_i  input  1  raw increment button, active-low, asynchronous to clk_i
load_hrs_o  output  8  hours BCD [7:4] tens, [3:0] units, 00–23
load_mins_o  output  8  minutes BCD, 00–59
load_secs_o  output  8  seconds BCD, 00–59
nLoadNow_o  output  1  active-low, one-cycle load strobe to clock2
editField_o  output  2  0 none, 1 hours, 2 minutes, 3 seconds
editing_o  output  1  high in any edit state
blink_o  output  1  blink phase for the field under edit

Behaviour:
- Reset (async assert, sync release) forces:
  - all FSM, synchronizer, debounce and blink registers to idle;
  - load_* = 8'h00, nLoadNow_o = 1, editField_o = 0, editing_o = 0, blink_o = 0.
  - Synchronizer and debounced levels reset to 1 (released).
- Input conditioning, per key:
  - 2-flop synchronizer, then a debounce counter.
  - Counter clears whenever the synced value equals the debounced level.
  - Debounced level flips when the count reaches DEBOUNCE_TC_P.
  - A press event is a one-cycle pulse, registered, on a 1→0 transition of the debounced level. Releases generate no event.
- FSM states: IDLE, HRS, MINS, SECS, COMMIT.
  - IDLE: mode event → HRS. Inc events are ignored.
  - HRS: inc increments hours BCD 00..23 and wraps 23 → 00. Mode event → MINS.
  - MINS: inc increments 00..59 and wraps 59 → 00. Mode event → SECS.
  - SECS: inc behaves as in MINS. Mode event → COMMIT.
  - COMMIT: exactly one cycle with nLoadNow_o = 0, then unconditionally → IDLE. Events arriving in COMMIT are dropped.
- BCD increment: units +1. At 9, units → 0 and tens +1. The field limit check (23 or 59) takes priority and wraps the whole field to 00.
- Edits start from the last committed or edited values; registers are not cleared on entering HRS.
- Simultaneous mode and inc events in the same cycle: mode wins and the inc is discarded (field unchanged).
- Outputs are registered, with one cycle of latency from event to field value change.
- editField_o per state: HRS = 1, MINS = 2, SECS = 3, IDLE and COMMIT = 0. editing_o = 1 in HRS, MINS and SECS only.
- Blink:
  - Counter and blink_o clear on every transition into HRS, MINS or SECS.
  - blink_o is held 0 in IDLE and COMMIT.
  - While editing, the counter runs 0..BLINK_TC_P and blink_o toggles on each wrap.
- Reset mid-edit: immediate return to IDLE with load_* = 00. No strobe is issued.
- load_* hold stable during and after the strobe, until the next edit.

Test Plan:
(all with DEBOUNCE_TC_P=3, BLINK_TC_P=7)
1. Reset asserted mid-run → all outputs at reset values in the same cycle (async), before any clock edge; after release, IDLE with editField_o = 0.
2. Glitch nModeKey_i low for 3 cycles → no state change. Hold it low for 8 cycles → editField_o = 1 exactly once; holding longer gives no second event.
3. In HRS, 23 inc presses → load_hrs_o = 8'h23; 24th press → 8'h00; a 10th press from 09 → 8'h10.
4. Full sequence entering 12:34:56, then a 4th mode press → nLoadNow_o low for exactly 1 cycle with load_hrs/mins/secs = 12/34/56, then IDLE with editing_o = 0. Values persist.
5. In MINS at 59, mode and inc debounced on the same cycle → state SECS, load_mins_o stays 8'h59. Separately, inc in IDLE → no change.
6. In MINS, run 20 cycles → blink_o toggles every 8 cycles. Assert nReset_i → IDLE, load_* = 00, nLoadNow_o never low.
